// File: rtl/ps2_pkg.sv
// Shared types and scan-code constants for the PS/2 keyboard command decoder.
//   rx_state_e       : receiver FSM states
//   SC_BREAK/SC_EXT  : break and extended prefix codes
//   SC_UP..SC_RIGHT  : extended arrow-key make codes
//   SC_COLOUR        : digit keys 1-8, which select a colour
package ps2_pkg;

    typedef enum logic [1:0] {
        RX_IDLE  = 2'd0,
        RX_RECV  = 2'd1,
        RX_CHECK = 2'd2
    } rx_state_e;

    localparam int unsigned BYTE_W     = 8;
    localparam int unsigned FRAME_BITS = 10;  // data + parity + stop, start not stored

    localparam logic [7:0] SC_BREAK = 8'hF0;
    localparam logic [7:0] SC_EXT   = 8'hE0;

    localparam logic [7:0] SC_UP    = 8'h75;
    localparam logic [7:0] SC_DOWN  = 8'h72;
    localparam logic [7:0] SC_LEFT  = 8'h6B;
    localparam logic [7:0] SC_RIGHT = 8'h74;

    localparam int unsigned NUM_COLOUR_KEYS = 8;
    localparam logic [7:0] SC_COLOUR [NUM_COLOUR_KEYS] = '{
        8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36, 8'h3D, 8'h3E
    };

    function automatic logic is_arrow(input logic [7:0] b);
        return (b == SC_UP) || (b == SC_DOWN) || (b == SC_LEFT) || (b == SC_RIGHT);
    endfunction

    function automatic logic is_colour(input logic [7:0] b);
        logic hit;
        hit = 1'b0;
        for (int i = 0; i < int'(NUM_COLOUR_KEYS); i++) begin
            if (b == SC_COLOUR[i]) hit = 1'b1;
        end
        return hit;
    endfunction

endpackage

// File: rtl/ps2_rx.sv
// PS/2 frame receiver: synchronizes the raw PS/2 lines, detects falling clock
// edges, assembles 11-bit frames and validates start/parity/stop, aborting a
// partial frame after TIMEOUT_CYCLES without a clock edge.
//   clk_i, reset_i     : system clock, synchronous active-high reset
//   ps2_clk_i/data_i   : raw asynchronous PS/2 lines
//   byte_valid_c_o     : high during the check cycle of a good frame
//   byte_data_c_o      : received byte, meaningful with byte_valid_c_o
//   frame_err_c_o      : high for one cycle when a frame is rejected
module ps2_rx
    import ps2_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 50000
) (
    input  logic       clk_i,
    input  logic       reset_i,
    input  logic       ps2_clk_i,
    input  logic       ps2_data_i,
    output logic       byte_valid_c_o,
    output logic [7:0] byte_data_c_o,
    output logic       frame_err_c_o
);

    localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam int unsigned BW = 4;

    logic [1:0]            clk_sync_q;
    logic [1:0]            data_sync_q;
    logic                  clk_prev_q;
    rx_state_e             state_q, state_d;
    logic [BW-1:0]         bit_cnt_q, bit_cnt_d;
    logic [FRAME_BITS-1:0] shift_q, shift_d;
    logic [TW-1:0]         tmo_q, tmo_d;

    logic fall;
    logic data_bit;

    assign fall          = clk_prev_q & ~clk_sync_q[1];
    assign data_bit      = data_sync_q[1];
    assign byte_data_c_o = shift_q[BYTE_W-1:0];

    // Synchronizers idle high so reset never fabricates a falling edge
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            clk_sync_q  <= 2'b11;
            data_sync_q <= 2'b11;
            clk_prev_q  <= 1'b1;
            state_q     <= RX_IDLE;
            bit_cnt_q   <= '0;
            shift_q     <= '0;
            tmo_q       <= '0;
        end else begin
            clk_sync_q  <= {clk_sync_q[0], ps2_clk_i};
            data_sync_q <= {data_sync_q[0], ps2_data_i};
            clk_prev_q  <= clk_sync_q[1];
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            shift_q     <= shift_d;
            tmo_q       <= tmo_d;
        end
    end

    // Frame assembly, validation and timeout
    always_comb begin
        state_d        = state_q;
        bit_cnt_d      = bit_cnt_q;
        shift_d        = shift_q;
        tmo_d          = tmo_q;
        byte_valid_c_o = 1'b0;
        frame_err_c_o  = 1'b0;

        if (fall) begin
            tmo_d = '0;
        end else if (state_q == RX_RECV) begin
            tmo_d = tmo_q + TW'(1);
        end

        unique case (state_q)
            RX_IDLE: begin
                if (fall) begin
                    if (!data_bit) begin
                        state_d   = RX_RECV;
                        bit_cnt_d = '0;
                    end else begin
                        frame_err_c_o = 1'b1;
                    end
                end
            end
            RX_RECV: begin
                if (fall) begin
                    // LSB-first: after ten shifts stop sits in [9], parity in [8]
                    shift_d = {data_bit, shift_q[FRAME_BITS-1:1]};
                    if (bit_cnt_q == BW'(FRAME_BITS - 1)) begin
                        state_d = RX_CHECK;
                    end else begin
                        bit_cnt_d = bit_cnt_q + BW'(1);
                    end
                end else if (tmo_q == TW'(TIMEOUT_CYCLES - 1)) begin
                    state_d       = RX_IDLE;
                    bit_cnt_d     = '0;
                    tmo_d         = '0;
                    frame_err_c_o = 1'b1;
                end
            end
            RX_CHECK: begin
                state_d = RX_IDLE;
                if ((^shift_q[BYTE_W:0]) && shift_q[FRAME_BITS-1]) begin
                    byte_valid_c_o = 1'b1;
                end else begin
                    frame_err_c_o = 1'b1;
                end
            end
            default: begin
                state_d = RX_IDLE;
            end
        endcase
    end

endmodule

// File: rtl/keyboard_command_decoder.sv
// Keyboard command decoder: turns PS/2 make codes into the character byte and
// one-cycle char/colour/move strobes for the display controller, discarding
// key releases and unknown extended keys.
//   clk, reset        : system clock, synchronous active-high reset
//   ps2_clk, ps2_data : raw PS/2 lines
//   character         : last accepted scan code
//   char_check        : ordinary key pressed
//   colour_check      : digit key 1-8 pressed
//   move_check        : arrow key pressed
//   frame_err         : frame rejected (start, parity, stop or timeout)
module keyboard_command_decoder
    import ps2_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 50000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic [7:0] character,
    output logic       char_check,
    output logic       colour_check,
    output logic       move_check,
    output logic       frame_err
);

    logic       rx_valid_c;
    logic [7:0] rx_byte_c;
    logic       rx_err_c;

    logic       brk_q, brk_d;
    logic       ext_q, ext_d;
    logic [7:0] char_q, char_d;
    logic       chr_q, chr_d;
    logic       col_q, col_d;
    logic       mov_q, mov_d;
    logic       err_q, err_d;

    ps2_rx #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_rx (
        .clk_i          (clk),
        .reset_i        (reset),
        .ps2_clk_i      (ps2_clk),
        .ps2_data_i     (ps2_data),
        .byte_valid_c_o (rx_valid_c),
        .byte_data_c_o  (rx_byte_c),
        .frame_err_c_o  (rx_err_c)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            brk_q  <= 1'b0;
            ext_q  <= 1'b0;
            char_q <= 8'h00;
            chr_q  <= 1'b0;
            col_q  <= 1'b0;
            mov_q  <= 1'b0;
            err_q  <= 1'b0;
        end else begin
            brk_q  <= brk_d;
            ext_q  <= ext_d;
            char_q <= char_d;
            chr_q  <= chr_d;
            col_q  <= col_d;
            mov_q  <= mov_d;
            err_q  <= err_d;
        end
    end

    // Prefix tracking and key classification; a release consumes both prefixes
    always_comb begin
        brk_d  = brk_q;
        ext_d  = ext_q;
        char_d = char_q;
        chr_d  = 1'b0;
        col_d  = 1'b0;
        mov_d  = 1'b0;
        err_d  = rx_err_c;

        if (rx_valid_c) begin
            if (rx_byte_c == SC_BREAK) begin
                brk_d = 1'b1;
            end else if (rx_byte_c == SC_EXT) begin
                ext_d = 1'b1;
            end else if (brk_q) begin
                brk_d = 1'b0;
                ext_d = 1'b0;
            end else if (ext_q) begin
                ext_d = 1'b0;
                if (is_arrow(rx_byte_c)) begin
                    mov_d  = 1'b1;
                    char_d = rx_byte_c;
                end
            end else if (is_colour(rx_byte_c)) begin
                col_d  = 1'b1;
                char_d = rx_byte_c;
            end else begin
                chr_d  = 1'b1;
                char_d = rx_byte_c;
            end
        end
    end

    assign character    = char_q;
    assign char_check   = chr_q;
    assign colour_check = col_q;
    assign move_check   = mov_q;
    assign frame_err    = err_q;

endmodule

// File: tb/tb_keyboard_command_decoder.sv
module tb_keyboard_command_decoder;

    localparam int unsigned TMO = 200;

    // Expected-event kinds, ordered as {char, colour, move, err}
    localparam logic [3:0] K_CHAR = 4'b1000;
    localparam logic [3:0] K_COL  = 4'b0100;
    localparam logic [3:0] K_MOVE = 4'b0010;
    localparam logic [3:0] K_ERR  = 4'b0001;

    typedef struct {
        logic [3:0] kind;
        logic [7:0] ch;
    } exp_t;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       ps2_clk = 1'b1;
    logic       ps2_data = 1'b1;
    logic [7:0] character;
    logic       char_check, colour_check, move_check, frame_err;

    exp_t exp_q[$];
    int   total = 0;
    int   bad = 0;
    logic [7:0] model_char = 8'h00;
    logic rst_q = 1'b1;

    keyboard_command_decoder #(
        .TIMEOUT_CYCLES(TMO)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .ps2_clk      (ps2_clk),
        .ps2_data     (ps2_data),
        .character    (character),
        .char_check   (char_check),
        .colour_check (colour_check),
        .move_check   (move_check),
        .frame_err    (frame_err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) rst_q <= reset;

    // Monitor: checks reset values, pops the scoreboard on every strobe and
    // checks that character holds between strobes.
    always @(negedge clk) begin
        logic [3:0] got;
        exp_t e;
        got = {char_check, colour_check, move_check, frame_err};
        if (rst_q) begin
            model_char = 8'h00;
            total++;
            if ({character, got} !== 12'h000) begin
                bad++;
                $display("FAIL reset_outputs: got char=%h strobes=%b, need 00/0000", character, got);
            end
        end else if (got !== 4'b0000) begin
            total++;
            if ($countones(got) != 1) begin
                bad++;
                $display("FAIL onehot: strobes=%b, need exactly one", got);
            end
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL unexpected_strobe: strobes=%b char=%h, need none", got, character);
            end else begin
                e = exp_q.pop_front();
                total++;
                if (got !== e.kind) begin
                    bad++;
                    $display("FAIL strobe_kind: got %b, need %b", got, e.kind);
                end
                if (e.kind != K_ERR) model_char = e.ch;
                total++;
                if (character !== model_char) begin
                    bad++;
                    $display("FAIL strobe_char: got %h, need %h", character, model_char);
                end
            end
        end else begin
            total++;
            if (character !== model_char) begin
                bad++;
                $display("FAIL char_hold: got %h, need %h", character, model_char);
            end
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic ps2_bit(input logic b);
        ps2_data = b;
        cyc(4);
        ps2_clk = 1'b0;
        cyc(8);
        ps2_clk = 1'b1;
        cyc(4);
    endtask

    // Sends the first n bits of a frame; bad_par inverts the parity bit
    task automatic send_bits(input logic [7:0] b, input logic bad_par, input int n);
        logic [10:0] f;
        f = {1'b1, (~^b) ^ bad_par, b, 1'b0};
        for (int i = 0; i < n; i++) ps2_bit(f[i]);
        ps2_data = 1'b1;
    endtask

    task automatic send(input logic [7:0] b);
        send_bits(b, 1'b0, 11);
        cyc(10);
    endtask

    task automatic expect_ev(input logic [3:0] k, input logic [7:0] c);
        exp_t e;
        e.kind = k;
        e.ch   = c;
        exp_q.push_back(e);
    endtask

    initial begin
        cyc(4);
        reset = 1'b0;
        cyc(4);

        // Plain character and a typematic repeat
        expect_ev(K_CHAR, 8'h1C); send(8'h1C);
        expect_ev(K_CHAR, 8'h1C); send(8'h1C);

        // Colour key press then release
        expect_ev(K_COL, 8'h16); send(8'h16);
        send(8'hF0); send(8'h16);

        // Arrow press, extended release, unknown extended key
        send(8'hE0);
        expect_ev(K_MOVE, 8'h75); send(8'h75);
        send(8'hE0); send(8'hF0); send(8'h75);
        send(8'hE0); send(8'h11);

        // Extended flag must be gone: 11 alone is a character
        expect_ev(K_CHAR, 8'h11); send(8'h11);

        // Parity error leaves character at 11
        expect_ev(K_ERR, 8'h00);
        send_bits(8'h1C, 1'b1, 11);
        cyc(10);

        // Start bit of 1
        expect_ev(K_ERR, 8'h00);
        ps2_bit(1'b1);
        cyc(10);

        // Timeout after 5 bits, then a clean frame
        expect_ev(K_ERR, 8'h00);
        send_bits(8'h2D, 1'b0, 5);
        cyc(TMO + 50);
        expect_ev(K_CHAR, 8'h2D); send(8'h2D);

        // Reset mid-frame, then a full frame
        send_bits(8'h55, 1'b0, 6);
        reset = 1'b1;
        cyc(3);
        reset = 1'b0;
        cyc(5);
        expect_ev(K_COL, 8'h1E); send(8'h1E);

        for (int i = 0; i < 2000 && exp_q.size() != 0; i++) cyc(1);
        cyc(20);
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL missing_strobes: %0d still pending, need 0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
